// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM state encoding and master ids.
package sp_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM macro pins seen by sp_ram_arbiter.
// Handshake: mN_req is held with we/addr/wdata stable until mN_gnt; a req&gnt cycle is
// exactly one RAM access, and a granted read returns mN_rvalid/mN_rdata one cycle later.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic                  m0_req;
  logic                  m0_we;
  logic                  m0_lock;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic                  m1_lock;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  ram_cen;
  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  ram_q,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_cen, ram_wen, ram_a, ram_d
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output ram_q,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_cen, ram_wen, ram_a, ram_d
  );

endinterface

// File: rtl/sp_ram_arb_rr2.sv
// Combinational 2-way grant selector. Round-robin on `last` by default; with
// SP_RAM_ARB_PRIO_EN defined, m0 has fixed priority outside a lock.
module sp_ram_arb_rr2
  import sp_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       owner,
  input  logic       locked,
  output logic [1:0] gnt
);

`ifdef SP_RAM_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    gnt = 2'b00;
    // During a lock only the owner can win; an idle owner leaves the RAM idle.
    if (locked) begin
      gnt = (owner == M1) ? {req[1], 1'b0} : {1'b0, req[0]};
    end
`ifdef SP_RAM_ARB_PRIO_EN
    else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`else
    else if (&req) begin
      gnt = (last == M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
`endif
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-master arbiter/sequencer in front of a single-port RAM with bounded bus locking.
// Define SP_RAM_ARB_PRIO_EN for fixed m0 priority instead of round-robin.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sp_ram_arbiter_if.slave   bus,
  output arb_state_t        dbg_state
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             last;
  logic             rd_vld;
  logic             rd_id;

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             owner;
  logic             timeout;
  logic             locked;
  logic             win_id;
  logic             win_we;
  logic             win_lock;
  logic             rv0;
  logic             rv1;

  // Requests are masked during reset so no access reaches the RAM.
  assign req     = {bus.m1_req, bus.m0_req} & {2{rst_n}};
  assign owner   = (state == LOCK1) ? M1 : M0;
  assign timeout = (lock_cnt == CNT_W'(LOCK_MAX));
  assign locked  = (state != IDLE) && !timeout &&
                   ((owner == M1) ? bus.m1_lock : bus.m0_lock);

  sp_ram_arb_rr2 u_rr2 (
    .req    (req),
    .last   (last),
    .owner  (owner),
    .locked (locked),
    .gnt    (gnt)
  );

  assign win_id   = gnt[1];
  assign win_we   = win_id ? bus.m1_we   : bus.m0_we;
  assign win_lock = win_id ? bus.m1_lock : bus.m0_lock;

  // A released or timed-out lock arbitrates like IDLE in that same cycle.
  always_comb begin
    state_nxt    = IDLE;
    lock_cnt_nxt = '0;
    if (locked) begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt + CNT_W'(1);
    end else if ((|gnt) && win_lock) begin
      state_nxt = win_id ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last     <= M1;
      rd_vld   <= 1'b0;
      rd_id    <= M0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rd_vld   <= (|gnt) && !win_we;
      if (|gnt) begin
        last <= win_id;
      end
      if ((|gnt) && !win_we) begin
        rd_id <= win_id;
      end
    end
  end

  always_comb begin
    bus.ram_cen = 1'b1;
    bus.ram_wen = 1'b1;
    bus.ram_a   = '0;
    bus.ram_d   = '0;
    if (|gnt) begin
      bus.ram_cen = 1'b0;
      bus.ram_wen = ~win_we;
      bus.ram_a   = win_id ? bus.m1_addr  : bus.m0_addr;
      bus.ram_d   = win_id ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  assign rv0 = rd_vld && (rd_id == M0);
  assign rv1 = rd_vld && (rd_id == M1);

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? bus.ram_q : '0;
  assign bus.m1_rdata  = rv1 ? bus.ram_q : '0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: vector table, hand sequences for lock/timeout/reset,
// and random traffic against a rule-level reference model with a RAM behavioural model.
module tb_sp_ram_arbiter;
  import sp_ram_arb_pkg::*;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 16;
`ifdef SP_RAM_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: one access per clock, read data registered
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!bus.ram_cen) begin
      if (!bus.ram_wen) mem[bus.ram_a] <= bus.ram_d;
      else              bus.ram_q      <= mem[bus.ram_a];
    end
  end

  // stimulus state
  bit            in_req   [2];
  bit            in_we    [2];
  bit            in_lk    [2];
  logic [AW-1:0] in_addr  [2];
  logic [DW-1:0] in_wdata [2];

  // reference model and scoreboard
  int            m_last;
  int            m_owner;
  int            m_held;
  int            last_win;
  logic [DW-1:0] shadow [256] = '{default: 8'h00};
  logic [DW-1:0] exp_q [$];
  int            exp_id_q [$];

  int checks = 0;
  int errors = 0;

  logic [1:0]    act_g;
  logic [1:0]    act_rv;
  logic [DW-1:0] act_rd0;
  logic [DW-1:0] act_rd1;

  typedef struct {
    logic r0, w0, l0; logic [7:0] a0, d0;
    logic r1, w1, l1; logic [7:0] a1, d1;
    logic [1:0] g, rv; logic [7:0] q0, q1;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic r0, w0, l0, input logic [7:0] a0, d0,
                              input logic r1, w1, l1, input logic [7:0] a1, d1,
                              input logic [1:0] g, rv, input logic [7:0] q0, q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g = g; v.rv = rv; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    bus.m0_req = in_req[0]; bus.m0_we = in_we[0]; bus.m0_lock = in_lk[0];
    bus.m0_addr = in_addr[0]; bus.m0_wdata = in_wdata[0];
    bus.m1_req = in_req[1]; bus.m1_we = in_we[1]; bus.m1_lock = in_lk[1];
    bus.m1_addr = in_addr[1]; bus.m1_wdata = in_wdata[1];
  endtask

  task automatic set_m(input int i, input bit r, input bit w, input bit l,
                       input logic [7:0] a, input logic [7:0] d);
    in_req[i] = r; in_we[i] = w; in_lk[i] = l; in_addr[i] = a; in_wdata[i] = d;
  endtask

  // One clock: drive inputs (at negedge), check against the model, advance the model.
  task automatic step(input string tag);
    int            win;
    int            id;
    bit            hold;
    logic [1:0]    exp_g;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];
    logic          exp_wen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    apply();
    #1;
    hold = (m_owner >= 0) && in_lk[m_owner] && (m_held < LOCK_MAX);
    if (hold)                       win = in_req[m_owner] ? m_owner : -1;
    else if (in_req[0] && in_req[1]) win = PRIO ? 0 : 1 - m_last;
    else if (in_req[0])             win = 0;
    else if (in_req[1])             win = 1;
    else                            win = -1;

    exp_g = 2'b00; exp_wen = 1'b1; exp_a = '0; exp_d = '0;
    if (win >= 0) begin
      exp_g[win] = 1'b1;
      exp_wen    = !in_we[win];
      exp_a      = in_addr[win];
      exp_d      = in_wdata[win];
    end
    exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
    if (exp_id_q.size() > 0) begin
      id         = exp_id_q.pop_front();
      exp_rv[id] = 1'b1;
      exp_rd[id] = exp_q.pop_front();
    end

    act_g   = {bus.m1_gnt, bus.m0_gnt};
    act_rv  = {bus.m1_rvalid, bus.m0_rvalid};
    act_rd0 = bus.m0_rdata;
    act_rd1 = bus.m1_rdata;
    chk({tag, " gnt"},     act_g,         exp_g);
    chk({tag, " ram_cen"}, bus.ram_cen,   win < 0);
    chk({tag, " ram_wen"}, bus.ram_wen,   exp_wen);
    chk({tag, " ram_a"},   bus.ram_a,     exp_a);
    chk({tag, " ram_d"},   bus.ram_d,     exp_d);
    chk({tag, " rvalid"},  act_rv,        exp_rv);
    chk({tag, " rdata0"},  act_rd0,       exp_rd[0]);
    chk({tag, " rdata1"},  act_rd1,       exp_rd[1]);

    if (hold) m_held++;
    else      m_owner = -1;
    if (win >= 0) begin
      m_last = win;
      if (!hold && in_lk[win]) begin
        m_owner = win;
        m_held  = 0;
      end
      if (in_we[win]) shadow[in_addr[win]] = in_wdata[win];
      else begin
        exp_q.push_back(shadow[in_addr[win]]);
        exp_id_q.push_back(win);
      end
    end
    last_win = win;
    @(negedge clk);
  endtask

  // Asserts reset with the current inputs held, checks the reset outputs, releases.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    apply();
    #1;
    chk({tag, " gnt"},     {bus.m1_gnt, bus.m0_gnt},       2'b00);
    chk({tag, " rvalid"},  {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
    chk({tag, " rdata0"},  bus.m0_rdata,                   0);
    chk({tag, " rdata1"},  bus.m1_rdata,                   0);
    chk({tag, " ram_cen"}, bus.ram_cen,                    1);
    chk({tag, " ram_wen"}, bus.ram_wen,                    1);
    chk({tag, " state"},   dbg_state,                      IDLE);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    m_last   = 1;
    m_owner  = -1;
    m_held   = 0;
    last_win = -1;
    exp_q.delete();
    exp_id_q.delete();
  endtask

  task automatic idle_both();
    set_m(0, 0, 0, 0, 8'h00, 8'h00);
    set_m(1, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_both();
    apply();
    @(negedge clk);
    do_reset("reset");

`ifndef SP_RAM_ARB_PRIO_EN
    //             m0: r w l  addr   data   m1: r w l  addr   data   gnt    rv     q0     q1
    vecs[0]  = mk(1, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00);
    vecs[1]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'h3C, 2'b10, 2'b00, 8'h00, 8'h00);
    vecs[2]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00);
    vecs[3]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b10, 2'b01, 8'hA5, 8'h00);
    vecs[4]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b10, 8'h00, 8'h3C);
    vecs[5]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b10, 2'b01, 8'hA5, 8'h00);
    vecs[6]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 8'h3C);
    vecs[7]  = mk(1, 1, 0, 8'h11, 8'h5A, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00);
    vecs[8]  = mk(1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00);
    vecs[9]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A, 8'h00);
    vecs[10] = mk(1, 0, 0, 8'h11, 8'h00, 1, 0, 1, 8'h20, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00);
    vecs[11] = mk(1, 0, 0, 8'h11, 8'h00, 1, 0, 1, 8'h20, 8'h00, 2'b10, 2'b10, 8'h00, 8'h3C);
    vecs[12] = mk(1, 0, 0, 8'h11, 8'h00, 1, 0, 1, 8'h20, 8'h00, 2'b10, 2'b10, 8'h00, 8'h3C);
    vecs[13] = mk(1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b10, 8'h00, 8'h3C);
    vecs[14] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A, 8'h00);
    vecs[15] = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h30, 8'h77, 2'b10, 2'b00, 8'h00, 8'h00);
    vecs[16] = mk(1, 0, 0, 8'h11, 8'h00, 0, 0, 1, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00);
    vecs[17] = mk(1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00);
    vecs[18] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A, 8'h00);

    for (int i = 0; i < 19; i++) begin
      set_m(0, vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0);
      set_m(1, vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
      step($sformatf("vec%0d model", i));
      chk($sformatf("vec%0d gnt", i),    act_g,   vecs[i].g);
      chk($sformatf("vec%0d rvalid", i), act_rv,  vecs[i].rv);
      chk($sformatf("vec%0d rdata0", i), act_rd0, vecs[i].q0);
      chk($sformatf("vec%0d rdata1", i), act_rd1, vecs[i].q1);
    end
`endif

    // lock timeout: m0 holds lock and req for 20 cycles, m1 keeps requesting
    do_reset("reset before timeout");
    for (int i = 0; i < 20; i++) begin
      set_m(0, 1, 1, 1, 8'h40, 8'(i));
      set_m(1, 1, 0, 0, 8'h20, 8'h00);
      step($sformatf("timeout c%0d model", i));
      chk($sformatf("timeout c%0d gnt", i), act_g, (i == 17 && !PRIO) ? 2'b10 : 2'b01);
      if (i == 10) chk("timeout lock state", dbg_state, LOCK0);
    end
    idle_both();
    step("timeout drain");

    // reset while locked with a read pending
    do_reset("reset before midlock");
    set_m(1, 1, 1, 1, 8'h50, 8'h99);
    step("midlock write");
    chk("midlock write gnt", act_g, 2'b10);
    set_m(0, 1, 0, 0, 8'h10, 8'h00);
    set_m(1, 1, 0, 1, 8'h50, 8'h00);
    step("midlock read");
    chk("midlock read gnt", act_g, 2'b10);
    do_reset("reset midlock");
    step("post-reset tie");
    chk("post-reset tie gnt", act_g, 2'b01);
    idle_both();
    step("post-reset drain");

`ifdef SP_RAM_ARB_PRIO_EN
    do_reset("reset before prio");
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1, 0, 0, 8'h10, 8'h00);
      set_m(1, 1, 0, 0, 8'h20, 8'h00);
      step($sformatf("prio c%0d model", i));
      chk($sformatf("prio c%0d gnt", i), act_g, 2'b01);
    end
    idle_both();
    step("prio drain");
`endif

    // random traffic against the reference model
    do_reset("reset before random");
    idle_both();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (in_req[i] && last_win != i) begin
          if ($urandom_range(0, 7) == 0) in_req[i] = 1'b0;
        end else begin
          in_req[i]   = ($urandom_range(0, 3) != 0);
          in_we[i]    = 1'($urandom_range(0, 1));
          in_addr[i]  = 8'($urandom_range(0, 15));
          in_wdata[i] = 8'($urandom);
        end
        if ($urandom_range(0, 3) == 0) in_lk[i] = ~in_lk[i];
      end
      step($sformatf("rand%0d", n));
    end
    idle_both();
    step("rand drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester arbiter and sequencer for the synchronous single-port RAM (active-low `cen`/`wen`, one access per clock, read data one cycle after the access).
- Shares the RAM between two masters using round-robin arbitration, with an optional bounded lock for back-to-back bursts.
- Returns read data to the requester that issued the read, tagged with a valid strobe.
- Sits directly in front of the RAM macro; the RAM sees exactly one master per cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `LOCK_MAX`, 16, maximum consecutive cycles a lock may hold the RAM (≥1)

Ports (N = 0, 1):
- `clk`  in  1  system clock, all state on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `mN_req`  in  1  access request, held until granted
- `mN_we`  in  1  1 = write, 0 = read
- `mN_lock`  in  1  keep ownership after this grant
- `mN_addr`  in  ADDR_WIDTH  access address
- `mN_wdata`  in  DATA_WIDTH  write data
- `mN_gnt`  out  1  access issued to RAM this cycle
- `mN_rvalid`  out  1  read data valid for this master
- `mN_rdata`  out  DATA_WIDTH  read data
- `ram_cen`  out  1  RAM chip select, active low
- `ram_wen`  out  1  RAM write enable, active low
- `ram_a`  out  ADDR_WIDTH  RAM address
- `ram_d`  out  DATA_WIDTH  RAM write data
- `ram_q`  in  DATA_WIDTH  RAM read data

## Operation
- Grant is combinational from the current `mN_req` and the registered state.
- At most one `mN_gnt` is high per cycle. A granted access drives the RAM pins in the same cycle:
  - `ram_cen = 0`
  - `ram_wen = ~mN_we`
  - `ram_a` / `ram_d` from the winner
- With no grant: `ram_cen = 1`, `ram_wen = 1`, `ram_a` / `ram_d` = 0.
- A requester that is not granted holds its `req`, `we`, `addr` and `wdata` stable. Dropping `req` before a grant is legal (withdrawal).
- Round-robin: register `last` holds the most recently granted master.
  - When both masters request, the master that is not `last` wins.
  - A lone request always wins.
- States:
  - IDLE: normal round-robin.
  - LOCK0 / LOCK1: only the owner may be granted. The other master waits even if the owner's `req` is low, and the RAM stays idle in that case.
- Transitions:
  - IDLE→LOCKN: on a grant to N with `mN_lock = 1`.
  - LOCKN→IDLE: on any cycle with `mN_lock = 0`. Arbitration in that same cycle is normal round-robin.
  - LOCKN→IDLE on timeout: lock counter reaches `LOCK_MAX`. The other master then wins the next contested cycle, because `last = N`.
- Lock counter:
  - Reset to 0 on entering LOCK.
  - Increments every cycle while in LOCK.
  - Width is clog2(`LOCK_MAX`+1).
- Read return: a granted read captures owner N in register `rd_pend`. In the next cycle:
  - `mN_rvalid = 1`
  - `mN_rdata = ram_q`
  - The other master's rdata is 0.
- Writes produce no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as `req`) when uncontested and unlocked.
- Read data latency: rvalid exactly 1 cycle after the gnt cycle.
- Throughput: one access per cycle. Back-to-back reads from alternating masters produce alternating rvalids.
- Reset values:
  - State IDLE, `last` = 1 (so m0 wins the first tie), lock counter 0, `rd_pend` empty.
  - While `rst_n = 0`: all gnt/rvalid 0, rdata 0, `ram_cen = 1`, `ram_wen = 1`.
- Reset asserted mid-lock or with a read pending: the pending rvalid is discarded and the state returns to IDLE.
- Simultaneous `mN_lock` release by the owner and a request from the other master: the other master wins that cycle.

## Configuration
- Macro `SP_RAM_ARB_PRIO_EN`.
- Defined: fixed priority, m0 always beats m1 in IDLE. `last` is not used for the decision but is still updated. Lock and timeout behave as without the macro.
- Undefined: round-robin as described above.

## Structure
- Shared package `sp_ram_arb_pkg`:
  - State enum: IDLE, LOCK0, LOCK1.
  - Master-id constants: M0 = 0, M1 = 1.
- Sub-module `sp_ram_arb_rr2`: combinational 2-way grant selector with inputs `req[1:0]`, `last`, `owner`, `locked` and output `gnt[1:0]`.
- The top level keeps the state register, lock counter, `rd_pend`, and the RAM/return muxing.

## Test plan
- m0 write addr 0x10 data 0xA5, then m0 read addr 0x10 → `m0_gnt` in both cycles; `m0_rvalid = 1` with `m0_rdata = 0xA5` the cycle after the read; `m1_rvalid` stays 0.
- Both masters request reads every cycle for 4 cycles after reset → grants m0, m1, m0, m1; rvalids alternate one cycle later.
- m1 asserts lock for 3 reads while m0 requests continuously → m1 granted 3 cycles; m0 granted in the cycle `m1_lock` drops.
- m0 holds lock and req for 20 cycles with `LOCK_MAX` = 16, m1 requesting → m1 granted on the cycle after the 16th locked cycle; no cycle ever has two grants.
- Reset asserted in the cycle after a granted read → no rvalid; `ram_cen = 1`; after release, m0 wins the first tie.
- With `SP_RAM_ARB_PRIO_EN` defined, both masters requesting for 3 cycles → m0 granted all 3, m1 never granted.
